iob_post_fifo: RTL and testbench

- Parametrised posted-write / ordered-request buffer between the FSB slave side (IOBS) and the IOB master (IOBM).
- Generalises the fixed two-level primary/secondary address-data latch scheme to DEPTH entries, with in-order issue of reads and non-posted writes behind posted writes.
- Posted writes terminate on the FSB at push; non-posted requests terminate when the IOB master reports completion.
- Sits on FCLK, between the chip-select/FSB termination logic and the IOB master request/ack interface.

---
 rtl/iob_post_fifo.sv | 175 +++++++++++++++++
 tb/tb_iob_post_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_post_fifo.sv
// Posted-write / ordered-request buffer between FSB slave termination and the IOB master; optional tail merge under IOB_WR_MERGE_EN.
// Latency: push to iob_req in 1 cycle; back-to-back issue with no idle cycles; np_done 1 cycle after iob_ack.
// Backpressure: req_ready drops when full or while a non-posted request is outstanding (a merging posted write bypasses full).
module iob_post_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 23,
    parameter int DW    = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          FCLK,
    input  logic          nRES,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic          req_posted,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    input  logic [1:0]    req_be,
    output logic          req_ready,
    output logic          np_done,
    output logic [DW-1:0] np_rdata,
    output logic          np_berr,
    output logic          iob_req,
    output logic          iob_write,
    output logic [AW-1:0] iob_addr,
    output logic [DW-1:0] iob_data,
    output logic [1:0]    iob_be,
    input  logic          iob_ack,
    input  logic          iob_berr,
    input  logic [DW-1:0] iob_rdata,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          pw_berr
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_BUSY  = 1'b1;
    localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);

    logic          r_mem_write  [DEPTH];
    logic          r_mem_posted [DEPTH];
    logic [AW-1:0] r_mem_addr   [DEPTH];
    logic [DW-1:0] r_mem_data   [DEPTH];
    logic [1:0]    r_mem_be     [DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [0:0]    r_state;
    logic          r_np_pending;
    logic          r_pw_berr;
    logic          r_np_done;
    logic          r_np_berr;
    logic [DW-1:0] r_np_rdata;

    logic          w_full;
    logic          w_empty;
    logic          w_np_req;
    logic          w_push;
    logic          w_pop;
    logic          w_head_posted;
    logic [PW:0]   w_count_nxt;

    assign w_full        = (r_count == L_DEPTH);
    assign w_empty       = (r_count == '0);
    assign w_np_req      = !req_write || !req_posted;
    assign w_pop         = (r_state == S_BUSY) && iob_ack;
    assign w_head_posted = r_mem_posted[r_rd_ptr];

`ifdef IOB_WR_MERGE_EN
    logic [PW-1:0] w_tail_ptr;
    logic          w_merge_hit;
    logic          w_merge;

    assign w_tail_ptr  = r_wr_ptr - PW'(1);
    // The head being presented to the IOB master must stay stable, so it never absorbs a merge.
    assign w_merge_hit = req_valid && req_write && req_posted && !w_empty
                      && r_mem_write[w_tail_ptr] && r_mem_posted[w_tail_ptr]
                      && (r_mem_addr[w_tail_ptr] == req_addr)
                      && !((r_state == S_BUSY) && (w_tail_ptr == r_rd_ptr));
    assign req_ready   = req_valid && !r_np_pending && (!w_full || w_merge_hit);
    assign w_push      = req_ready && !w_merge_hit;
    assign w_merge     = req_ready && w_merge_hit;
`else
    assign req_ready   = req_valid && !r_np_pending && !w_full;
    assign w_push      = req_ready;
`endif

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PW+1)'(1);
            2'b01:   w_count_nxt = r_count - (PW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_write[i]  <= 1'b0;
                r_mem_posted[i] <= 1'b0;
                r_mem_addr[i]   <= '0;
                r_mem_data[i]   <= '0;
                r_mem_be[i]     <= '0;
            end
        end else if (w_push) begin
            r_mem_write[r_wr_ptr]  <= req_write;
            r_mem_posted[r_wr_ptr] <= req_write && req_posted;
            r_mem_addr[r_wr_ptr]   <= req_addr;
            r_mem_data[r_wr_ptr]   <= req_data;
            r_mem_be[r_wr_ptr]     <= req_be;
        end
`ifdef IOB_WR_MERGE_EN
        else if (w_merge) begin
            r_mem_be[w_tail_ptr] <= r_mem_be[w_tail_ptr] | req_be;
            if (req_be[0]) r_mem_data[w_tail_ptr][DW/2-1:0]  <= req_data[DW/2-1:0];
            if (req_be[1]) r_mem_data[w_tail_ptr][DW-1:DW/2] <= req_data[DW-1:DW/2];
        end
`endif
    end

    always_ff @(posedge FCLK) begin
        if (!nRES) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_IDLE;
            r_np_pending <= 1'b0;
            r_pw_berr    <= 1'b0;
            r_np_done    <= 1'b0;
            r_np_berr    <= 1'b0;
            r_np_rdata   <= '0;
        end else begin
            r_np_done <= 1'b0;
            r_count   <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && w_np_req) r_np_pending <= 1'b1;

            if (w_pop) begin
                if (!w_head_posted) begin
                    r_np_done    <= 1'b1;
                    r_np_rdata   <= iob_rdata;
                    r_np_berr    <= iob_berr;
                    r_np_pending <= 1'b0;
                end else if (iob_berr) begin
                    r_pw_berr <= 1'b1;
                end
            end

            // Entering BUSY on the push itself gives the 1-cycle push-to-request latency.
            case (r_state)
                S_IDLE:  if (!w_empty || w_push) r_state <= S_BUSY;
                S_BUSY:  if (w_pop && (w_count_nxt == '0)) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign iob_req   = (r_state == S_BUSY);
    assign iob_write = r_mem_write[r_rd_ptr];
    assign iob_addr  = r_mem_addr[r_rd_ptr];
    assign iob_data  = r_mem_data[r_rd_ptr];
    assign iob_be    = r_mem_be[r_rd_ptr];

    assign np_done   = r_np_done;
    assign np_rdata  = r_np_rdata;
    assign np_berr   = r_np_berr;
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign pw_berr   = r_pw_berr;

endmodule

// File: tb/tb_iob_post_fifo.sv
// Bench for iob_post_fifo at DEPTH=2: issue-order scoreboard plus non-posted completion scoreboard.
module tb_iob_post_fifo;

    localparam int DEPTH = 2;
    localparam int AW    = 23;
    localparam int DW    = 16;

    logic          FCLK;
    logic          nRES;
    logic          req_valid, req_write, req_posted;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [1:0]    req_be;
    logic          req_ready;
    logic          np_done, np_berr;
    logic [DW-1:0] np_rdata;
    logic          iob_req, iob_write;
    logic [AW-1:0] iob_addr;
    logic [DW-1:0] iob_data;
    logic [1:0]    iob_be;
    logic          iob_ack, iob_berr;
    logic [DW-1:0] iob_rdata;
    logic [1:0]    count;
    logic          full, empty, pw_berr;

    iob_post_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .FCLK(FCLK), .nRES(nRES),
        .req_valid(req_valid), .req_write(req_write), .req_posted(req_posted),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be), .req_ready(req_ready),
        .np_done(np_done), .np_rdata(np_rdata), .np_berr(np_berr),
        .iob_req(iob_req), .iob_write(iob_write), .iob_addr(iob_addr),
        .iob_data(iob_data), .iob_be(iob_be),
        .iob_ack(iob_ack), .iob_berr(iob_berr), .iob_rdata(iob_rdata),
        .count(count), .full(full), .empty(empty), .pw_berr(pw_berr)
    );

    typedef struct packed {
        logic          w;
        logic          p;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    be;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] rd;
        logic          berr;
    } np_t;

    exp_t sb_q[$];
    np_t  np_q[$];
    logic exp_pw_berr;
    int   checks;
    int   failures;

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge FCLK);
        #1;
    endtask

    // Issue monitor: every accepted handshake must present the oldest outstanding request.
    always @(negedge FCLK) begin
        if (nRES && iob_req && iob_ack) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected got addr=%h required no issue", iob_addr);
            end else begin
                if ({iob_write, iob_addr, iob_data, iob_be} !== {sb_q[0].w, sb_q[0].a, sb_q[0].d, sb_q[0].be}) begin
                    failures++;
                    $display("FAIL issue_order got w=%b a=%h d=%h be=%b required w=%b a=%h d=%h be=%b",
                             iob_write, iob_addr, iob_data, iob_be, sb_q[0].w, sb_q[0].a, sb_q[0].d, sb_q[0].be);
                end
                void'(sb_q.pop_front());
            end
        end
        if (nRES && np_done) begin
            checks++;
            if (np_q.size() == 0) begin
                failures++;
                $display("FAIL np_unexpected got np_done=1 required 0");
            end else begin
                if ({np_rdata, np_berr} !== {np_q[0].rd, np_q[0].berr}) begin
                    failures++;
                    $display("FAIL np_result got rdata=%h berr=%b required rdata=%h berr=%b",
                             np_rdata, np_berr, np_q[0].rd, np_q[0].berr);
                end
                void'(np_q.pop_front());
            end
        end
    end

    task automatic push_req(input logic w, input logic p, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] be, output logic acc);
        req_valid = 1'b1; req_write = w; req_posted = p;
        req_addr = a; req_data = d; req_be = be;
        #2;
        acc = req_ready;
        if (acc) sb_q.push_back('{w: w, p: (w & p), a: a, d: d, be: be});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ack_set(input logic berr, input logic [DW-1:0] rd);
        for (int i = 0; i < 20 && iob_req !== 1'b1; i++) tick();
        checks++;
        if (iob_req !== 1'b1) begin
            failures++;
            $display("FAIL ack_wait got iob_req=%b required 1", iob_req);
        end else begin
            if (sb_q.size() > 0) begin
                if (!sb_q[0].p) np_q.push_back('{rd: rd, berr: berr});
                else if (berr) exp_pw_berr = 1'b1;
            end
            iob_ack = 1'b1; iob_berr = berr; iob_rdata = rd;
        end
    endtask

    task automatic ack(input logic berr, input logic [DW-1:0] rd);
        ack_set(berr, rd);
        tick();
        iob_ack = 1'b0; iob_berr = 1'b0; iob_rdata = '0;
    endtask

    task automatic test_reset;
        nRES = 1'b0;
        tick(); tick();
        nRES = 1'b1;
        #1;
        checks++;
        if ({iob_req, count, empty, full, pw_berr, np_done, np_berr, np_rdata, req_ready} !== {1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got req=%b cnt=%0d e=%b f=%b pwb=%b npd=%b npb=%b npr=%h rdy=%b required 0 0 1 0 0 0 0 0000 0",
                     iob_req, count, empty, full, pw_berr, np_done, np_berr, np_rdata, req_ready);
        end
    endtask

    task automatic test_basic;
        logic acc;
        push_req(1'b1, 1'b1, 23'h7FF000, 16'h1234, 2'b11, acc);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL basic_ready got %b required 1", acc); end
        checks++;
        if ({iob_req, iob_addr, iob_data, iob_be} !== {1'b1, 23'h7FF000, 16'h1234, 2'b11}) begin
            failures++;
            $display("FAIL basic_issue got req=%b a=%h d=%h be=%b required 1 7ff000 1234 11", iob_req, iob_addr, iob_data, iob_be);
        end
        ack(1'b0, '0);
        checks++;
        if ({iob_req, count, empty} !== {1'b0, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL basic_drain got req=%b cnt=%0d e=%b required 0 0 1", iob_req, count, empty);
        end
    endtask

    task automatic test_fill;
        logic acc;
        push_req(1'b1, 1'b1, 23'h000010, 16'hA001, 2'b11, acc);
        push_req(1'b1, 1'b1, 23'h000020, 16'hA002, 2'b11, acc);
        req_valid = 1'b1; req_write = 1'b1; req_posted = 1'b1;
        req_addr = 23'h000030; req_data = 16'hA003; req_be = 2'b11;
        #2;
        checks++;
        if ({req_ready, full, count} !== {1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL fill_full got rdy=%b f=%b cnt=%0d required 0 1 2", req_ready, full, count);
        end
        tick();
        ack_set(1'b0, '0);
        #2;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_pop_same_cycle got rdy=%b required 0", req_ready); end
        tick();
        iob_ack = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_after_pop got rdy=%b required 1", req_ready);
        end else begin
            sb_q.push_back('{w: 1'b1, p: 1'b1, a: 23'h000030, d: 16'hA003, be: 2'b11});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin failures++; $display("FAIL fill_count got %0d required 2", count); end
        ack(1'b0, '0);
        ack(1'b0, '0);
    endtask

    task automatic test_ordering;
        logic acc;
        push_req(1'b1, 1'b1, 23'h100000, 16'h5555, 2'b11, acc);
        push_req(1'b0, 1'b1, 23'h580000, 16'h0000, 2'b11, acc);
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL order_read_ready got %b required 1", acc); end
        ack(1'b0, '0);
        checks++;
        if ({iob_req, iob_write, iob_addr} !== {1'b1, 1'b0, 23'h580000}) begin
            failures++;
            $display("FAIL order_back_to_back got req=%b w=%b a=%h required 1 0 580000", iob_req, iob_write, iob_addr);
        end
        ack(1'b0, 16'hBEEF);
        checks++;
        if ({np_done, np_rdata, np_berr} !== {1'b1, 16'hBEEF, 1'b0}) begin
            failures++;
            $display("FAIL order_np_done got done=%b rd=%h berr=%b required 1 beef 0", np_done, np_rdata, np_berr);
        end
        tick();
        checks++;
        if ({np_done, iob_req} !== 2'b00) begin
            failures++;
            $display("FAIL order_pulse got done=%b req=%b required 0 0", np_done, iob_req);
        end
    endtask

    task automatic test_errors;
        logic acc;
        push_req(1'b1, 1'b1, 23'h200000, 16'h0F0F, 2'b11, acc);
        ack(1'b1, '0);
        tick(); tick();
        checks++;
        if (pw_berr !== exp_pw_berr) begin failures++; $display("FAIL err_pw_sticky got %b required %b", pw_berr, exp_pw_berr); end
        push_req(1'b0, 1'b0, 23'h300000, 16'h0000, 2'b11, acc);
        req_valid = 1'b1; req_write = 1'b0; req_posted = 1'b0;
        req_addr = 23'h300001; req_data = '0; req_be = 2'b11;
        #2;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL err_second_read got rdy=%b required 0", req_ready); end
        req_valid = 1'b0;
        tick();
        ack(1'b1, 16'h1111);
        checks++;
        if ({np_done, np_berr, pw_berr} !== {1'b1, 1'b1, exp_pw_berr}) begin
            failures++;
            $display("FAIL err_np_berr got done=%b berr=%b pwb=%b required 1 1 %b", np_done, np_berr, pw_berr, exp_pw_berr);
        end
        tick();
    endtask

    task automatic test_reset_busy;
        logic acc;
        push_req(1'b1, 1'b1, 23'h400000, 16'h0001, 2'b11, acc);
        push_req(1'b1, 1'b1, 23'h400001, 16'h0002, 2'b11, acc);
        checks++;
        if ({iob_req, count} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL rstb_setup got req=%b cnt=%0d required 1 2", iob_req, count);
        end
        nRES = 1'b0;
        tick();
        nRES = 1'b1;
        sb_q.delete();
        exp_pw_berr = 1'b0;
        checks++;
        if ({iob_req, count, empty, pw_berr} !== {1'b0, 2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rstb_state got req=%b cnt=%0d e=%b pwb=%b required 0 0 1 0", iob_req, count, empty, pw_berr);
        end
        iob_ack = 1'b1;
        tick();
        iob_ack = 1'b0;
        checks++;
        if ({iob_req, count, empty, np_done} !== {1'b0, 2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rstb_late_ack got req=%b cnt=%0d e=%b npd=%b required 0 0 1 0", iob_req, count, empty, np_done);
        end
    endtask

    task automatic test_merge;
        logic acc;
        push_req(1'b1, 1'b1, 23'h010000, 16'h1111, 2'b11, acc);
        push_req(1'b1, 1'b1, 23'h020000, 16'h00AA, 2'b01, acc);
        req_valid = 1'b1; req_write = 1'b1; req_posted = 1'b1;
        req_addr = 23'h020000; req_data = 16'hBB00; req_be = 2'b10;
        #2;
`ifdef IOB_WR_MERGE_EN
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL merge_ready got %b required 1", req_ready); end
        sb_q[sb_q.size()-1].be = 2'b11;
        sb_q[sb_q.size()-1].d  = 16'hBBAA;
        tick();
        req_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin failures++; $display("FAIL merge_count got %0d required 2", count); end
`else
        checks++;
        if ({req_ready, count} !== {1'b0, 2'd2}) begin
            failures++;
            $display("FAIL nomerge_refuse got rdy=%b cnt=%0d required 0 2", req_ready, count);
        end
        tick();
        ack_set(1'b0, '0);
        tick();
        iob_ack = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL nomerge_accept got rdy=%b required 1", req_ready);
        end else begin
            sb_q.push_back('{w: 1'b1, p: 1'b1, a: 23'h020000, d: 16'hBB00, be: 2'b10});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (count !== 2'd2) begin failures++; $display("FAIL nomerge_count got %0d required 2", count); end
`endif
        while (sb_q.size() > 0 && iob_req === 1'b1) ack(1'b0, '0);
    endtask

    initial begin
        checks = 0; failures = 0; exp_pw_berr = 1'b0;
        nRES = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_posted = 1'b0;
        req_addr = '0; req_data = '0; req_be = '0;
        iob_ack = 1'b0; iob_berr = 1'b0; iob_rdata = '0;

        test_reset();
        test_basic();
        test_fill();
        test_ordering();
        test_errors();
        test_reset_busy();
        test_merge();

        tick(); tick();
        checks++;
        if ({sb_q.size() == 0, np_q.size() == 0, empty, iob_req} !== 4'b1110) begin
            failures++;
            $display("FAIL final_drain got sb=%0d np=%0d e=%b req=%b required 0 0 1 0", sb_q.size(), np_q.size(), empty, iob_req);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
